// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Contents: default stack-pointer index/reset value, architectural register
// name indices, and a clog2 helper for deriving the address width.
package regfile_pkg;

    localparam int          SP_IDX_DEF  = 29;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_7FFC;

    // Architectural register names
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // Smallest r such that 2**r >= value (value >= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between writeback/decode logic and the register file.
// Signals: two write ports (we/waddr/wdata 0 and 1), per-port read enables
// re[NRD], packed read addresses raddr[NRD*AW], packed read data
// rdata[NRD*DW] and the write-conflict flag.
// master: the pipeline side driving requests; slave: the register file.
interface regfile_mp_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic              we0;
    logic [AW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic              we1;
    logic [AW-1:0]     waddr1;
    logic [DW-1:0]     wdata1;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic              wr_conflict;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr,
        input  rdata, wr_conflict
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr,
        output rdata, wr_conflict
    );
endinterface

// File: rtl/regfile_rdport.sv
// One registered read port of the register file.
// Ports: clk/rst_n; re_i/raddr_i read request; rf_val_i array contents at
// raddr_i; wen*/waddr*/wdata* qualified write ports for bypass; rdata_o
// registered read data (holds when re_i is low).
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic [DW-1:0] rf_val_i,
    input  logic          wen0_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          wen1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;
    logic          hit0_s;
    logic          hit1_s;

    // The write enables arrive already qualified, so a zero-register write
    // never shows up as a hit here.
    assign hit0_s = (BYPASS != 0) && wen0_i && (waddr0_i == raddr_i);
    assign hit1_s = (BYPASS != 0) && wen1_i && (waddr1_i == raddr_i);

    // Next read data: zero register, then port 1 bypass, port 0 bypass, array
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            if ((ZERO_REG != 0) && (raddr_i == {AW{1'b0}})) begin
                rdata_d = {DW{1'b0}};
            end else if (hit1_s) begin
                rdata_d = wdata1_i;
            end else if (hit0_s) begin
                rdata_d = wdata0_i;
            end else begin
                rdata_d = rf_val_i;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DW{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two prioritised write ports, NRD registered
// read ports with optional write-to-read bypass, hardwired zero register and
// a programmable reset value for the stack pointer.
// Ports: clk, rst_n (async active-low), bus (regfile_mp_if.slave) carrying
// the write ports, read enables/addresses, read data and wr_conflict.
// DEPTH must be a power of two, so every address is in range.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          DEPTH    = 32,
    parameter int          NRD      = 2,
    parameter int          BYPASS   = 1,
    parameter int          ZERO_REG = 1,
    parameter int          SP_IDX   = SP_IDX_DEF,
    parameter logic [DW-1:0] SP_INIT = DW'(SP_INIT_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);

    localparam int AW = clog2(DEPTH);

    logic [DW-1:0]     regs_q [DEPTH];
    logic              wen0_s;
    logic              wen1_s;
    logic              conflict_d;
    logic              conflict_q;
    logic [NRD*DW-1:0] rdata_s;

    // Writes to the zero register are dropped before they reach the array,
    // the bypass paths or the conflict detector.
    assign wen0_s = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == {AW{1'b0}}));
    assign wen1_s = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == {AW{1'b0}}));

    assign conflict_d = wen0_s && wen1_s && (bus.waddr0 == bus.waddr1);

    // Register array: port 1 is applied last so it wins a same-address write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : {DW{1'b0}};
            end
        end else begin
            if (wen0_s) begin
                regs_q[bus.waddr0] <= bus.wdata0;
            end
            if (wen1_s) begin
                regs_q[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    // Write-conflict flag, valid for the cycle after the colliding writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] raddr_s;
        logic [DW-1:0] rf_val_s;

        assign raddr_s  = bus.raddr[g*AW +: AW];
        assign rf_val_s = regs_q[raddr_s];

        regfile_rdport #(
            .DW       (DW),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .re_i     (bus.re[g]),
            .raddr_i  (raddr_s),
            .rf_val_i (rf_val_s),
            .wen0_i   (wen0_s),
            .waddr0_i (bus.waddr0),
            .wdata0_i (bus.wdata0),
            .wen1_i   (wen1_s),
            .waddr1_i (bus.waddr1),
            .wdata1_i (bus.wdata1),
            .rdata_o  (rdata_s[g*DW +: DW])
        );
    end

    assign bus.rdata       = rdata_s;
    assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one instance with bypass and one without,
// driven by identical stimulus and checked against a behavioural model.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic clk;
    logic rst_n;

    logic              we0;
    logic [AW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic              we1;
    logic [AW-1:0]     waddr1;
    logic [DW-1:0]     wdata1;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;

    regfile_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus_b ();
    regfile_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus_n ();

    assign bus_b.we0 = we0;     assign bus_n.we0 = we0;
    assign bus_b.waddr0 = waddr0; assign bus_n.waddr0 = waddr0;
    assign bus_b.wdata0 = wdata0; assign bus_n.wdata0 = wdata0;
    assign bus_b.we1 = we1;     assign bus_n.we1 = we1;
    assign bus_b.waddr1 = waddr1; assign bus_n.waddr1 = waddr1;
    assign bus_b.wdata1 = wdata1; assign bus_n.wdata1 = wdata1;
    assign bus_b.re = re;       assign bus_n.re = re;
    assign bus_b.raddr = raddr; assign bus_n.raddr = raddr;

    regfile_mp #(.DW(DW), .DEPTH(32), .NRD(NRD), .BYPASS(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    regfile_mp #(.DW(DW), .DEPTH(32), .NRD(NRD), .BYPASS(0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NRD*DW-1:0] rb;
        logic [NRD*DW-1:0] rn;
        logic              conf;
    } sb_t;

    sb_t sbq[$];

    logic [DW-1:0] mem   [32];
    logic [DW-1:0] exp_b [NRD];
    logic [DW-1:0] exp_n [NRD];

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[29] = 32'h0000_7FFC;
        for (int i = 0; i < NRD; i++) begin
            exp_b[i] = 32'h0;
            exp_n[i] = 32'h0;
        end
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
        we1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
        re  = 2'b00;
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        re    = en;
        raddr = {a1, a0};
    endtask

    // Predict this cycle's outcome, push it, clock, then pop and compare.
    task automatic cycle();
        sb_t e;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        logic w0, w1;
        w0 = we0 && (waddr0 != 5'd0);
        w1 = we1 && (waddr1 != 5'd0);
        for (int i = 0; i < NRD; i++) begin
            if (re[i]) begin
                a = raddr[i*AW +: AW];
                v = mem[a];
                exp_n[i] = v;
                if (w1 && waddr1 == a)      exp_b[i] = wdata1;
                else if (w0 && waddr0 == a) exp_b[i] = wdata0;
                else                        exp_b[i] = v;
                if (a == 5'd0) begin
                    exp_b[i] = 32'h0;
                    exp_n[i] = 32'h0;
                end
            end
            e.rb[i*DW +: DW] = exp_b[i];
            e.rn[i*DW +: DW] = exp_n[i];
        end
        e.conf = w0 && w1 && (waddr0 == waddr1);
        if (w0) mem[waddr0] = wdata0;
        if (w1) mem[waddr1] = wdata1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        for (int i = 0; i < NRD; i++) begin
            check_val($sformatf("rd%0d_byp", i), bus_b.rdata[i*DW +: DW], e.rb[i*DW +: DW]);
            check_val($sformatf("rd%0d_nobyp", i), bus_n.rdata[i*DW +: DW], e.rn[i*DW +: DW]);
        end
        check_val("conflict_byp", {31'd0, bus_b.wr_conflict}, {31'd0, e.conf});
        check_val("conflict_nobyp", {31'd0, bus_n.wr_conflict}, {31'd0, e.conf});
    endtask

    initial begin
        idle();
        raddr = 10'd0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_rdata_b", bus_b.rdata[31:0], 32'h0);
        check_val("rst_conf", {31'd0, bus_b.wr_conflict}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values: SP and an ordinary register
        set_rd(2'b11, 5'd29, 5'd5);
        cycle();
        check_val("sp_reset", bus_b.rdata[31:0], 32'h0000_7FFC);
        check_val("r5_reset", bus_b.rdata[63:32], 32'h0);

        // Basic write then read
        idle();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        cycle();
        idle();
        set_rd(2'b01, 5'd5, 5'd0);
        cycle();
        check_val("r5_write", bus_b.rdata[31:0], 32'hDEAD_BEEF);

        // Zero register: both ports write r0, no conflict
        idle();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h1234;
        set_rd(2'b11, 5'd0, 5'd0);
        cycle();
        check_val("r0_conf", {31'd0, bus_b.wr_conflict}, 32'h0);
        idle();
        set_rd(2'b11, 5'd0, 5'd0);
        cycle();
        check_val("r0_read", bus_b.rdata[31:0], 32'h0);

        // Collision on r7: port 1 wins, flag for exactly one cycle
        idle();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        cycle();
        check_val("r7_conf_set", {31'd0, bus_b.wr_conflict}, 32'h1);
        idle();
        set_rd(2'b11, 5'd7, 5'd7);
        cycle();
        check_val("r7_conf_clr", {31'd0, bus_b.wr_conflict}, 32'h0);
        check_val("r7_value", bus_b.rdata[63:32], 32'h22);

        // Bypass: old r3 = 1111, write A5A5 while reading r3 on both ports
        idle();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1111;
        cycle();
        idle();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5;
        set_rd(2'b11, 5'd3, 5'd3);
        cycle();
        check_val("byp_p0", bus_b.rdata[31:0], 32'hA5A5);
        check_val("byp_p1", bus_b.rdata[63:32], 32'hA5A5);
        check_val("nobyp_p0", bus_n.rdata[31:0], 32'h1111);

        // Both write ports hit the read address: port 1 data bypasses
        idle();
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hAA;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hBB;
        set_rd(2'b01, 5'd4, 5'd3);
        cycle();
        check_val("byp_both", bus_b.rdata[31:0], 32'hBB);

        // Hold: port 1 disabled while address changes and writes happen
        idle();
        set_rd(2'b10, 5'd0, 5'd3);
        cycle();
        for (int k = 0; k < 3; k++) begin
            idle();
            we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hC000 + k;
            set_rd(2'b01, 5'd6, 5'(8 + k));
            cycle();
        end
        check_val("hold_p1", bus_b.rdata[63:32], 32'hA5A5);

        // Reset in the middle of a write cycle
        idle();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
        set_rd(2'b11, 5'd5, 5'd3);
        cycle();
        idle();
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hAA;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_p0", bus_b.rdata[31:0], 32'h0);
        check_val("midrst_p1", bus_n.rdata[63:32], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle();
        set_rd(2'b11, 5'd9, 5'd10);
        cycle();
        check_val("r10_discard", bus_b.rdata[63:32], 32'h0);

        // Random traffic over a small address window to provoke collisions
        for (int k = 0; k < 300; k++) begin
            we0    = 1'($urandom_range(0, 1));
            waddr0 = 5'($urandom_range(0, 7));
            wdata0 = $urandom;
            we1    = 1'($urandom_range(0, 1));
            waddr1 = 5'($urandom_range(0, 7));
            wdata1 = $urandom;
            set_rd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Configurable data width, depth, read-port count and two write ports with fixed priority.
- Registered (1-cycle) reads with optional write-to-read bypass, hardwired zero register, and a programmable reset value for the stack-pointer register.
- Sits in the decode stage; read data feeds the ALU operand muxes, writes come from writeback.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of 2, at least 2.
- AW, log2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write to a read address appears on that read's output; 0 = the read returns the old value.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 32'h0000_7FFC, reset value of register SP_IDX; all other registers reset to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write-enable, port 0 (writeback).
- waddr0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- we1  in  1  write-enable, port 1 (load/secondary writeback).
- waddr1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- re  in  NRD  per-port read-enable; bit i is read port i.
- raddr  in  NRD*AW  packed read addresses; port i occupies [i*AW +: AW].
- rdata  out  NRD*DW  packed registered read data; port i occupies [i*DW +: DW].
- wr_conflict  out  1  registered flag; set the cycle after both write ports targeted the same non-zero address.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, except register SP_IDX = SP_INIT. rdata = 0 and wr_conflict = 0 immediately. Reset mid-write discards that write.
- Writes on posedge clk:
  - Port 0 and port 1 write independently.
  - Same address on both ports in one cycle: port 1 wins; wr_conflict goes to 1 the next cycle for one cycle.
  - ZERO_REG=1: writes to address 0 are dropped and never raise wr_conflict.
- Reads on posedge clk, per port i:
  - re[i]=1: the rdata slice loads the register value.
  - re[i]=0: the rdata slice holds its previous value.
  - Read latency is exactly 1 cycle.
- Bypass:
  - BYPASS=1: if raddr_i matches an enabled write address this cycle, rdata_i gets the write data. If both write ports match, port 1's data is used.
  - BYPASS=0: rdata_i gets the pre-write contents.
  - ZERO_REG=1: address 0 reads 0 regardless of bypass.
- Any two read ports may use the same address; each returns identical data.
- Out-of-range addresses cannot occur (DEPTH = 2^AW).
- No other state machine. The only sequential state is the register array, the rdata registers and the wr_conflict flop.

Decomposition:
- Shared package regfile_pkg holds:
  - the SP_IDX/SP_INIT defaults;
  - the clog2 helper for AW;
  - the register-name index constants (ZERO=0, SP=29, RA=31).
- Natural sub-module: regfile_rdport. It holds one read port's address compare, bypass mux and output register. It is instantiated NRD times in a generate loop.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → rdata=0 asynchronously. After release, read r29 → 32'h0000_7FFC; read r5 → 0.
- Basic write/read: we0=1, waddr0=5, wdata0=32'hDEADBEEF. Next cycle re=2'b01, raddr0=5 → rdata0=32'hDEADBEEF one cycle later.
- Zero register: write r0=32'h1234 on both ports → r0 reads 0 and wr_conflict stays 0.
- Collision: we0 and we1 both target r7 with 32'h11 and 32'h22 → r7=32'h22 and wr_conflict=1 for exactly one cycle.
- Bypass: BYPASS=1, write r3=32'hA5A5 while reading r3 on both ports in the same cycle → both rdata=32'hA5A5 next cycle. Rebuild with BYPASS=0 → old value returned.
- Hold: re=0 on port 1 while raddr1 changes and r-writes occur → rdata1 stays unchanged.
